aemb2_dwb_arb: RTL

AEMB2_DWB_ARB -- requirements
Module: aemb2_dwb_arb

---
 rtl/aemb2_dwb_arb.sv | 131 +++++++++++++
 1 files changed

// File: rtl/aemb2_dwb_arb.sv
// Two-master Wishbone data-bus arbiter for the AEMB2 core.
// Round-robin between two masters, with cycle lock and a bus-timeout abort.
// While a master owns the bus, the slave-side signals are a combinational mux.
module aemb2_dwb_arb #(
  parameter int AEMB_DWB = 32,
  parameter int TMO      = 255
) (
  input  logic                gclk,
  input  logic                grst,
  // master 0
  input  logic [AEMB_DWB-1:2] m0_adr_i,
  input  logic [3:0]          m0_sel_i,
  input  logic                m0_stb_i,
  input  logic                m0_cyc_i,
  input  logic                m0_wre_i,
  input  logic [31:0]         m0_dat_i,
  output logic [31:0]         m0_dat_o,
  output logic                m0_ack_o,
  output logic                m0_err_o,
  // master 1
  input  logic [AEMB_DWB-1:2] m1_adr_i,
  input  logic [3:0]          m1_sel_i,
  input  logic                m1_stb_i,
  input  logic                m1_cyc_i,
  input  logic                m1_wre_i,
  input  logic [31:0]         m1_dat_i,
  output logic [31:0]         m1_dat_o,
  output logic                m1_ack_o,
  output logic                m1_err_o,
  // slave
  output logic [AEMB_DWB-1:2] s_adr_o,
  output logic [3:0]          s_sel_o,
  output logic                s_stb_o,
  output logic                s_cyc_o,
  output logic                s_wre_o,
  output logic [31:0]         s_dat_o,
  input  logic [31:0]         s_dat_i,
  input  logic                s_ack_i,
  output logic [1:0]          gnt_o
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUS0 = 2'd1,
    ST_BUS1 = 2'd2
  } state_t;

  localparam logic [7:0] TMO_L = 8'(TMO);

  state_t     r_state;
  state_t     w_nxt;
  logic [1:0] r_gnt;
  logic       r_lst;      // last master that owned the bus
  logic       w_lst_nxt;
  logic [7:0] r_cnt;      // cycles the current strobe has waited for ack
  logic       w_bus;
  logic       w_tmo;

  assign w_bus = r_gnt[0] | r_gnt[1];

  // Ack has priority over timeout: a timeout only fires while ack is low.
  assign w_tmo = w_bus & (r_cnt == TMO_L) & ~s_ack_i;

  // Slave-side mux; master 0 is also the idle default for the data fields.
  assign s_adr_o = r_gnt[1] ? m1_adr_i : m0_adr_i;
  assign s_sel_o = r_gnt[1] ? m1_sel_i : m0_sel_i;
  assign s_wre_o = r_gnt[1] ? m1_wre_i : m0_wre_i;
  assign s_dat_o = r_gnt[1] ? m1_dat_i : m0_dat_i;
  assign s_stb_o = w_bus & ~w_tmo & (r_gnt[1] ? m1_stb_i : m0_stb_i);
  assign s_cyc_o = w_bus & ~w_tmo & (r_gnt[1] ? m1_cyc_i : m0_cyc_i);

  assign m0_dat_o = s_dat_i;
  assign m1_dat_o = s_dat_i;
  assign m0_ack_o = s_ack_i & r_gnt[0] & m0_stb_i;
  assign m1_ack_o = s_ack_i & r_gnt[1] & m1_stb_i;
  assign m0_err_o = w_tmo & r_gnt[0];
  assign m1_err_o = w_tmo & r_gnt[1];

  assign gnt_o = r_gnt;

  // Next-state and last-grant pointer: round-robin from idle, lock while cyc is held.
  always_comb begin
    // NOTE: defaults first so every path assigns both outputs and no latch is inferred.
    w_nxt     = r_state;
    w_lst_nxt = r_lst;
    case (r_state)
      ST_IDLE: begin
        if (m0_cyc_i && m1_cyc_i) w_nxt = r_lst ? ST_BUS0 : ST_BUS1;
        else if (m0_cyc_i)        w_nxt = ST_BUS0;
        else if (m1_cyc_i)        w_nxt = ST_BUS1;
      end
      ST_BUS0: begin
        if (w_tmo) begin
          w_nxt     = ST_IDLE;
          w_lst_nxt = 1'b0;
        end else if (!m0_cyc_i) begin
          w_nxt     = m1_cyc_i ? ST_BUS1 : ST_IDLE;
          w_lst_nxt = 1'b0;
        end
      end
      ST_BUS1: begin
        if (w_tmo) begin
          w_nxt     = ST_IDLE;
          w_lst_nxt = 1'b1;
        end else if (!m1_cyc_i) begin
          w_nxt     = m0_cyc_i ? ST_BUS0 : ST_IDLE;
          w_lst_nxt = 1'b1;
        end
      end
      default: w_nxt = ST_IDLE;
    endcase
  end

  // State, registered grant, pointer and saturating wait counter.
  always_ff @(posedge gclk) begin
    // NOTE: reset is synchronous here (sampled only on the clock edge), and all state uses <=.
    if (grst) begin
      r_state <= ST_IDLE;
      r_gnt   <= 2'b00;
      r_lst   <= 1'b1;   // "m1 went last" so m0 wins the first tie
      r_cnt   <= 8'd0;
    end else begin
      r_state <= w_nxt;
      r_gnt   <= {w_nxt == ST_BUS1, w_nxt == ST_BUS0};
      r_lst   <= w_lst_nxt;
      if ((w_nxt != r_state) || s_ack_i || !s_stb_o) r_cnt <= 8'd0;
      else if (r_cnt != 8'hFF)                        r_cnt <= r_cnt + 8'd1;
    end
  end

endmodule
